neurotransmitter_integrator: RTL
================================

// Module: neurotransmitter_integrator
// PURPOSE
//  Parametrised per-neurotransmitter level integrator. Accumulates inc/dec/fast
//  requests from a *_regulator block into a saturating WIDTH-bit level. Decays
//  toward a baseline when no request is present. Publishes the 2-bit quantised
//  code that the regulators consume in neurotransmitter_level.
//  One instance per transmitter (CORT, DOP, GABA, NE, SER).
// PARAMETERS
//  WIDTH        8    level register width (>=3)
//  SLOW_STEP    1    step applied for inc/dec without fast
//  FAST_STEP    4    step applied when fast is latched
//  PRESCALE     16   en ticks per update strobe (>=1)
//  DECAY_PERIOD 8    consecutive request-free strobes before one decay step (>=1)
//  BASELINE     128  decay target level
//  RESET_LEVEL  128  level loaded on reset
//  T1/T2/T3     64/128/192  quantisation thresholds, T1<=T2<=T3<=2^WIDTH-1
// PORTS
//  clk      in   1      system clock
//  rst      in   1      asynchronous, active-high reset
//  en       in   1      time-base tick; all state advances only on en=1
//  inc      in   1      increase request from regulator
//  dec      in   1      decrease request from regulator
//  fast     in   1      use FAST_STEP for this update
//  level    out  WIDTH  current level
//  level_q  out  2      quantised level: <T1:00, <T2:01, <T3:10, else 11
//  at_max   out  1      level == 2^WIDTH-1
//  at_min   out  1      level == 0
//  changed  out  1      one-cycle pulse when level changed on this strobe
// BEHAVIOUR
//  Reset (async, rst=1): level=RESET_LEVEL; prescaler, idle counter, pending
//   latches and changed = 0. level_q, at_max and at_min are decoded from
//   RESET_LEVEL.
//  Capture: on every clk with en=1, OR inc/dec/fast into pending_inc/dec/fast.
//   This keeps single-tick pulses between strobes.
//  Prescaler: counts en ticks 0..PRESCALE-1. The strobe occurs on the en tick
//   where the count equals PRESCALE-1; the count then wraps to 0.
//   The strobe-cycle inputs are included in the update (OR'd with the pending
//   latches). All pending latches clear on the strobe.
//  Update on strobe, using the resolved request (pending OR current inputs):
//   inc&!dec: level += step, saturating at 2^WIDTH-1; idle counter := 0
//   dec&!inc: level -= step, saturating at 0;         idle counter := 0
//   inc&dec : conflict; level holds; idle counter := 0 (a conflict is not idle)
//   neither : idle counter += 1. When it reaches DECAY_PERIOD, level moves 1
//             toward BASELINE (no move if already equal) and the counter
//             clears to 0.
//   step = FAST_STEP if fast is resolved, else SLOW_STEP. fast alone does not
//   count as a request.
//  Arithmetic is done at WIDTH+1 bits and clamped. No wrap-around is permitted.
//  Latency: level updates in the cycle after the strobe edge.
//   level_q, at_max and at_min are combinational decodes of the level register
//   (no extra latency).
//  changed = 1 for exactly one clk after a strobe that altered level,
//   including decay moves. It is 0 otherwise, including a saturated no-op.
//  en=0: all state frozen; changed deasserts after its one cycle.
//  Reset mid-accumulation discards pending requests and any partial prescale
//   or idle count.
// TESTING
//  1 Reset: rst pulse -> level=128, level_q=10, changed=0, at_max=at_min=0.
//  2 Pulse capture: PRESCALE=16; inc on en tick 3 only -> on strobe (tick 15)
//    level 128->129 and changed pulses once.
//  3 Saturation: level=254, inc+fast strobe -> level=255, at_max=1; next
//    inc strobe -> level stays 255, changed=0.
//  4 Conflict: inc and dec in the same window -> level unchanged, idle count
//    cleared, so the decay timer restarts.
//  5 Decay: level=130, no requests -> after 8 strobes level=129; after 16
//    strobes level=128; further strobes leave 128, changed=0.
//  6 Async reset mid-window: pending dec plus rst asserted between clk edges ->
//    outputs immediately reset values; next strobe with no request = no change.

Source files
------------

// File: rtl/neurotransmitter_integrator.sv
// Per-transmitter level integrator: accumulates regulator inc/dec requests into a
// saturating level, decays toward a baseline when idle, and publishes a 2-bit code.
module neurotransmitter_integrator #(
  parameter int WIDTH        = 8,
  parameter int SLOW_STEP    = 1,
  parameter int FAST_STEP    = 4,
  parameter int PRESCALE     = 16,
  parameter int DECAY_PERIOD = 8,
  parameter int BASELINE     = 128,
  parameter int RESET_LEVEL  = 128,
  parameter int T1           = 64,
  parameter int T2           = 128,
  parameter int T3           = 192
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  input  logic             fast,
  output logic [WIDTH-1:0] level,
  output logic [1:0]       level_q,
  output logic             at_max,
  output logic             at_min,
  output logic             changed
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = $clog2(DECAY_PERIOD + 1);

  localparam logic [WIDTH:0]   MAX_W   = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]   SLOW_W  = (WIDTH+1)'(SLOW_STEP);
  localparam logic [WIDTH:0]   FAST_W  = (WIDTH+1)'(FAST_STEP);
  localparam logic [WIDTH:0]   T1_W    = (WIDTH+1)'(T1);
  localparam logic [WIDTH:0]   T2_W    = (WIDTH+1)'(T2);
  localparam logic [WIDTH:0]   T3_W    = (WIDTH+1)'(T3);
  localparam logic [WIDTH-1:0] BASE_L  = WIDTH'(BASELINE);
  localparam logic [WIDTH-1:0] RST_L   = WIDTH'(RESET_LEVEL);
  localparam logic [PW-1:0]    PRE_TC  = PW'(PRESCALE - 1);
  localparam logic [IW-1:0]    IDLE_TC = IW'(DECAY_PERIOD);

  logic [PW-1:0]    pre_cnt;
  logic [IW-1:0]    idle_cnt;
  logic             pend_inc;
  logic             pend_dec;
  logic             pend_fast;

  logic             strobe;
  logic             req_inc;
  logic             req_dec;
  logic             req_fast;
  logic [WIDTH:0]   step;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [IW-1:0]    idle_inc;
  logic [IW-1:0]    idle_nxt;
  logic [WIDTH-1:0] level_nxt;

  assign strobe   = en && (pre_cnt == PRE_TC);
  assign req_inc  = pend_inc  | inc;
  assign req_dec  = pend_dec  | dec;
  assign req_fast = pend_fast | fast;
  assign step     = req_fast ? FAST_W : SLOW_W;
  assign sum      = {1'b0, level} + step;
  // The extra top bit of diff acts as the borrow flag for clamping at zero.
  assign diff     = {1'b0, level} - step;
  assign idle_inc = idle_cnt + 1'b1;

  always_comb begin
    level_nxt = level;
    idle_nxt  = '0;
    if (req_inc && !req_dec) begin
      level_nxt = (sum > MAX_W) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    end else if (req_dec && !req_inc) begin
      level_nxt = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
    end else if (!req_inc && !req_dec) begin
      if (idle_inc == IDLE_TC) begin
        if (level < BASE_L) begin
          level_nxt = level + 1'b1;
        end else if (level > BASE_L) begin
          level_nxt = level - 1'b1;
        end
      end else begin
        idle_nxt = idle_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level     <= RST_L;
      pre_cnt   <= '0;
      idle_cnt  <= '0;
      pend_inc  <= 1'b0;
      pend_dec  <= 1'b0;
      pend_fast <= 1'b0;
      changed   <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (en) begin
        if (strobe) begin
          pre_cnt   <= '0;
          pend_inc  <= 1'b0;
          pend_dec  <= 1'b0;
          pend_fast <= 1'b0;
          level     <= level_nxt;
          idle_cnt  <= idle_nxt;
          changed   <= (level_nxt != level);
        end else begin
          pre_cnt   <= pre_cnt + 1'b1;
          pend_inc  <= req_inc;
          pend_dec  <= req_dec;
          pend_fast <= req_fast;
        end
      end
    end
  end

  always_comb begin
    if ({1'b0, level} < T1_W) begin
      level_q = 2'b00;
    end else if ({1'b0, level} < T2_W) begin
      level_q = 2'b01;
    end else if ({1'b0, level} < T3_W) begin
      level_q = 2'b10;
    end else begin
      level_q = 2'b11;
    end
  end

  assign at_max = (level == {WIDTH{1'b1}});
  assign at_min = (level == '0);

endmodule
